// File: rtl/moving_avg.sv
// Boxcar (moving-average) filter over the last 2**LOG2_LEN strobed samples.
// The filter produces a running sum, an averaged sample, a one-cycle valid pulse
// for each sample accepted once the window is full, and a 'filled' level.
// Optional feature macro: MOVING_AVG_ROUND_EN
//   defined   -> avg = (sum + LEN/2) >> LOG2_LEN  (round half up)
//   undefined -> avg = sum >> LOG2_LEN            (truncate; no rounding adder)
`timescale 1ns/1ps

module moving_avg #(
    parameter int D_WIDTH  = 12,
    parameter int LOG2_LEN = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [D_WIDTH-1:0]          in,
    input  logic                        en,
    input  logic                        clr,
    output logic [D_WIDTH+LOG2_LEN-1:0] sum,
    output logic [D_WIDTH-1:0]          avg,
    output logic                        valid,
    output logic                        filled
);

    localparam int LEN = 1 << LOG2_LEN;
    localparam int S_W = D_WIDTH + LOG2_LEN;
    localparam int C_W = LOG2_LEN + 1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [C_W-1:0]     count_q, count_d;
    logic [D_WIDTH-1:0] hist_q [LEN];
    logic [D_WIDTH-1:0] hist_d [LEN];
    logic [S_W-1:0]     sum_q, sum_d;
    logic [D_WIDTH-1:0] avg_q, avg_d;
    logic               valid_q, valid_d;
    logic               filled_q, filled_d;

`ifdef MOVING_AVG_ROUND_EN
    localparam logic [S_W-1:0] HALF = S_W'(LEN / 2);
    // The worst case LEN*(2**D_WIDTH-1) + LEN/2 stays below 2**S_W, so no carry is lost.
    logic [S_W-1:0] rnd_sum;
`endif

    // Next-state logic: flush, shift/accumulate on a strobe, or hold.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        count_d  = count_q;
        hist_d   = hist_q;
        sum_d    = sum_q;
        avg_d    = avg_q;
        valid_d  = 1'b0;
        filled_d = filled_q;
`ifdef MOVING_AVG_ROUND_EN
        rnd_sum  = '0;
`endif

        if (clr) begin
            // Flush discards any sample offered in the same cycle.
            state_d  = FILL;
            count_d  = '0;
            sum_d    = '0;
            avg_d    = '0;
            filled_d = 1'b0;
            for (int k = 0; k < LEN; k++) begin
                hist_d[k] = '0;
            end
        end else if (en) begin
            hist_d[0] = in;
            for (int k = 1; k < LEN; k++) begin
                hist_d[k] = hist_q[k-1];
            end
            // Zeroed history makes the fill phase exact: the dropped sample is 0 until full.
            sum_d = sum_q + S_W'(in) - S_W'(hist_q[LEN-1]);
`ifdef MOVING_AVG_ROUND_EN
            rnd_sum = sum_d + HALF;
            avg_d   = rnd_sum[S_W-1:LOG2_LEN];
`else
            avg_d   = sum_d[S_W-1:LOG2_LEN];
`endif
            valid_d = (state_q == RUN) || (count_q == C_W'(LEN - 1));
            if (state_q == FILL) begin
                count_d = count_q + C_W'(1);
                if (count_q == C_W'(LEN - 1)) begin
                    state_d  = RUN;
                    filled_d = 1'b1;
                end
            end
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q  <= FILL;
            count_q  <= '0;
            sum_q    <= '0;
            avg_q    <= '0;
            valid_q  <= 1'b0;
            filled_q <= 1'b0;
            // NOTE: the history must be cleared on reset because the sum relies on zeros shifting out.
            for (int k = 0; k < LEN; k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            avg_q    <= avg_d;
            valid_q  <= valid_d;
            filled_q <= filled_d;
            for (int k = 0; k < LEN; k++) begin
                hist_q[k] <= hist_d[k];
            end
        end
    end

    assign sum    = sum_q;
    assign avg    = avg_q;
    assign valid  = valid_q;
    assign filled = filled_q;

endmodule
